// File: rtl/abz_decoder.sv
// Quadrature A/B/Z receiver: synchronise and glitch-filter the encoder lines, decode x4 steps
// into a signed position, latch position on Z index and measure the step-to-step period.
module abz_decoder #(
    parameter int FILT_LEN = 4,
    parameter int POS_W    = 32,
    parameter int PER_W    = 16
) (
    input  logic             clk_in,
    input  logic             sys_rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             z_in,
    input  logic             dec_en,
    input  logic             pos_clr,
    input  logic             z_clr_en,
    output logic [POS_W-1:0] position,
    output logic             dir,
    output logic             step,
    output logic [POS_W-1:0] z_latch,
    output logic             z_valid,
    output logic [PER_W-1:0] period,
    output logic             err
);

    localparam logic [3:0]       FILT_TC = 4'(FILT_LEN - 1);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);
    localparam logic [PER_W-1:0] PER_ONE = PER_W'(1);
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    // bit 0 = A, bit 1 = B, bit 2 = Z
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_filt;
    logic [3:0]       r_fcnt [3];
    logic [1:0]       r_prev;
    logic             r_z_prev;
    logic [POS_W-1:0] r_position;
    logic [POS_W-1:0] r_z_latch;
    logic [PER_W-1:0] r_period;
    logic [PER_W-1:0] r_cnt;
    logic             r_dir;
    logic             r_step;
    logic             r_z_valid;
    logic             r_err;

    logic [2:0] w_raw;
    logic [1:0] w_cur;
    logic       w_fwd;
    logic       w_rev;
    logic       w_ill;
    logic       w_zrise;

    assign w_raw   = {z_in, b_in, a_in};
    assign w_cur   = {r_filt[0], r_filt[1]};
    assign w_zrise = r_filt[2] & ~r_z_prev;

    // A level only propagates after holding steady against the filtered value for FILT_LEN cycles
    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_filt  <= '0;
            for (int i = 0; i < 3; i++) r_fcnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FILT_TC) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 4'd1;
                end
            end
        end
    end

    // {prev, cur} as {a,b,a,b}; forward order is 00 -> 10 -> 11 -> 01
    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_ill = 1'b0;
        case ({r_prev, w_cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: w_rev = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: w_ill = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (sys_rst) begin
            r_prev     <= '0;
            r_z_prev   <= 1'b0;
            r_position <= '0;
            r_z_latch  <= '0;
            r_step     <= 1'b0;
            r_z_valid  <= 1'b0;
            r_err      <= 1'b0;
            r_dir      <= 1'b0;
            r_cnt      <= '0;
            r_period   <= PER_MAX;
        end else begin
            // prev tracks even while disabled so re-enabling cannot create a step
            r_prev    <= w_cur;
            r_z_prev  <= r_filt[2];
            r_step    <= 1'b0;
            r_z_valid <= 1'b0;
            if (dec_en) begin
                if (w_fwd || w_rev) begin
                    r_step     <= 1'b1;
                    r_dir      <= w_fwd;
                    r_position <= w_fwd ? r_position + POS_ONE : r_position - POS_ONE;
                    r_period   <= (r_cnt == PER_MAX) ? PER_MAX : r_cnt + PER_ONE;
                    r_cnt      <= '0;
                end else if (r_cnt == PER_MAX) begin
                    r_period <= PER_MAX;
                end else begin
                    r_cnt <= r_cnt + PER_ONE;
                end
                if (w_ill) r_err <= 1'b1;
                if (w_zrise) begin
                    r_z_latch <= r_position;
                    r_z_valid <= 1'b1;
                    if (z_clr_en) r_position <= '0;
                end
            end
            if (pos_clr) begin
                r_position <= '0;
                r_err      <= 1'b0;
                r_cnt      <= '0;
                r_period   <= PER_MAX;
            end
        end
    end

    assign position = r_position;
    assign dir      = r_dir;
    assign step     = r_step;
    assign z_latch  = r_z_latch;
    assign z_valid  = r_z_valid;
    assign period   = r_period;
    assign err      = r_err;

endmodule

// File: tb/tb_abz_decoder.sv
// Bench for abz_decoder: directed scenarios plus random quadrature traffic, every cycle checked
// against a behavioural model built from sample histories and phase arithmetic.
module tb_abz_decoder;

    localparam logic [15:0] PMAX = 16'hFFFF;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic        sys_rst, a_in, b_in, z_in, dec_en, pos_clr, z_clr_en;
    logic [31:0] position, z_latch;
    logic        dir, step, z_valid, err;
    logic [15:0] period;

    abz_decoder #(.FILT_LEN(4), .POS_W(32), .PER_W(16)) dut (
        .clk_in(clk_in), .sys_rst(sys_rst), .a_in(a_in), .b_in(b_in), .z_in(z_in),
        .dec_en(dec_en), .pos_clr(pos_clr), .z_clr_en(z_clr_en),
        .position(position), .dir(dir), .step(step), .z_latch(z_latch),
        .z_valid(z_valid), .period(period), .err(err)
    );

    int errors = 0;
    int checks = 0;
    int n_step = 0;
    int n_zv   = 0;
    int qidx   = 0;
    bit chk_on = 1'b0;

    // model state; h_x[0] is the newest raw sample
    logic [5:0]  h_a, h_b, h_z;
    bit          m_af, m_bf, m_zf, m_ap, m_bp, m_zp;
    logic [31:0] m_pos, m_zl;
    bit          m_dir, m_step, m_zv, m_err;
    logic [15:0] m_per;
    int          m_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int phase(bit a, bit b);
        if (!a && !b) return 0;
        if (a && !b)  return 1;
        if (a && b)   return 2;
        return 3;
    endfunction

    // filtered level follows raw samples taken 2..5 cycles ago once all four agree
    function automatic bit filt_next(bit f, logic [5:0] h);
        if (h[4:1] == 4'b1111) return 1'b1;
        if (h[4:1] == 4'b0000) return 1'b0;
        return f;
    endfunction

    always @(posedge clk_in) begin : model
        int d, mv;
        bit ill, zr;
        logic [31:0] pos0;
        if (sys_rst) begin
            h_a = '0; h_b = '0; h_z = '0;
            m_af = 0; m_bf = 0; m_zf = 0; m_ap = 0; m_bp = 0; m_zp = 0;
            m_pos = '0; m_zl = '0; m_dir = 0; m_step = 0; m_zv = 0; m_err = 0;
            m_per = PMAX; m_cnt = 0;
        end else begin
            d    = (phase(m_af, m_bf) - phase(m_ap, m_bp) + 4) % 4;
            mv   = (d == 1) ? 1 : (d == 3) ? -1 : 0;
            ill  = (d == 2);
            zr   = m_zf && !m_zp;
            pos0 = m_pos;
            m_step = 0;
            m_zv   = 0;
            if (dec_en) begin
                if (mv != 0) begin
                    m_step = 1;
                    m_dir  = (mv > 0);
                    m_pos  = m_pos + 32'(mv);
                    m_per  = 16'((m_cnt + 1 > 65535) ? 65535 : m_cnt + 1);
                    m_cnt  = 0;
                end else if (m_cnt >= 65535) begin
                    m_per = PMAX;
                end else begin
                    m_cnt++;
                end
                if (ill) m_err = 1;
                if (zr) begin
                    m_zl = pos0;
                    m_zv = 1;
                    if (z_clr_en) m_pos = '0;
                end
            end
            if (pos_clr) begin
                m_pos = '0; m_err = 0; m_cnt = 0; m_per = PMAX;
            end
            m_ap = m_af; m_bp = m_bf; m_zp = m_zf;
            m_af = filt_next(m_af, h_a);
            m_bf = filt_next(m_bf, h_b);
            m_zf = filt_next(m_zf, h_z);
            h_a = {h_a[4:0], a_in};
            h_b = {h_b[4:0], b_in};
            h_z = {h_z[4:0], z_in};
        end
    end

    always @(negedge clk_in) begin
        if (chk_on) begin
            check("position", position, m_pos);
            check("dir", 32'(dir), 32'(m_dir));
            check("step", 32'(step), 32'(m_step));
            check("z_latch", z_latch, m_zl);
            check("z_valid", 32'(z_valid), 32'(m_zv));
            check("period", 32'(period), 32'(m_per));
            check("err", 32'(err), 32'(m_err));
            if (step) n_step++;
            if (z_valid) n_zv++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic set_ab(input int p);
        case (p)
            0: begin a_in = 0; b_in = 0; end
            1: begin a_in = 1; b_in = 0; end
            2: begin a_in = 1; b_in = 1; end
            default: begin a_in = 0; b_in = 1; end
        endcase
    endtask

    task automatic quarters(input int n, input int dirn, input int hold);
        repeat (n) begin
            qidx = (qidx + dirn + 4) % 4;
            set_ab(qidx);
            tick(hold);
        end
    endtask

    task automatic clr_pulse();
        pos_clr = 1; tick(1); pos_clr = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pos"}, position, 32'd0);
        check({tag, "_zl"}, z_latch, 32'd0);
        check({tag, "_per"}, 32'(period), 32'hFFFF);
        check({tag, "_flags"}, {28'd0, dir, step, z_valid, err}, 32'd0);
    endtask

    initial begin
        sys_rst = 1; a_in = 0; b_in = 0; z_in = 0;
        dec_en = 0; pos_clr = 0; z_clr_en = 0;
        tick(3);
        chk_on = 1;
        check_reset_vals("reset");
        sys_rst = 0; dec_en = 1;

        // forward 8 full cycles
        n_step = 0;
        quarters(32, 1, 10); tick(10);
        check("t1_pos", position, 32'd32);
        check("t1_dir", 32'(dir), 32'd1);
        check("t1_per", 32'(period), 32'd10);
        check("t1_err", 32'(err), 32'd0);
        check("t1_steps", n_step, 32'd32);

        quarters(16, -1, 10); tick(10);
        check("t2_pos", position, 32'd16);
        check("t2_dir", 32'(dir), 32'd0);
        check("t2_per", 32'(period), 32'd10);

        // glitches on A with B low
        n_step = 0;
        a_in = 1; tick(3); a_in = 0; tick(15);
        check("glitch3_pos", position, 32'd16);
        check("glitch3_steps", n_step, 32'd0);
        a_in = 1; tick(4); a_in = 0; tick(5);
        check("glitch4_pos", position, 32'd17);
        tick(10);
        check("glitch4_back", position, 32'd16);

        // illegal 00 -> 11
        a_in = 1; b_in = 1; qidx = 2; tick(20);
        check("t4_err", 32'(err), 32'd1);
        check("t4_pos", position, 32'd16);
        clr_pulse();
        check("t4_clr_err", 32'(err), 32'd0);
        check("t4_clr_pos", position, 32'd0);
        check("t4_clr_per", 32'(period), 32'hFFFF);

        // Z index capture with and without clear
        quarters(5, 1, 10); tick(10);
        check("t5_pos", position, 32'd5);
        n_zv = 0; z_clr_en = 1;
        z_in = 1; tick(30); z_in = 0; tick(10);
        check("t5_zl", z_latch, 32'd5);
        check("t5_nzv", n_zv, 32'd1);
        check("t5_pos_clr", position, 32'd0);
        quarters(3, 1, 10); tick(10);
        n_zv = 0; z_clr_en = 0;
        z_in = 1; tick(30); z_in = 0; tick(10);
        check("t5b_zl", z_latch, 32'd3);
        check("t5b_nzv", n_zv, 32'd1);
        check("t5b_pos", position, 32'd3);

        // wrap below zero
        clr_pulse();
        quarters(1, -1, 10); tick(10);
        check("t6_wrap", position, 32'hFFFF_FFFF);

        // random traffic
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                quarters(1, ($urandom_range(0, 1) != 0) ? 1 : -1, $urandom_range(1, 12));
            end else if (r < 78) begin
                int g;
                g = $urandom_range(1, 6);
                if ($urandom_range(0, 1) != 0) begin
                    a_in = ~a_in; tick(g); a_in = ~a_in;
                end else begin
                    b_in = ~b_in; tick(g); b_in = ~b_in;
                end
                tick($urandom_range(1, 8));
            end else if (r < 84) begin
                qidx = (qidx + 2) % 4; set_ab(qidx); tick($urandom_range(1, 12));
            end else if (r < 88) begin
                z_clr_en = 1'($urandom_range(0, 1));
                z_in = 1; tick($urandom_range(1, 10)); z_in = 0; tick($urandom_range(1, 6));
            end else if (r < 93) begin
                dec_en = ~dec_en; tick($urandom_range(1, 10));
            end else begin
                clr_pulse();
            end
        end
        dec_en = 1; z_in = 0; z_clr_en = 0;
        tick(20);

        // reset in the middle of motion
        quarters(1, 1, 5);
        sys_rst = 1; tick(1);
        check_reset_vals("midrst");
        sys_rst = 0;
        tick(20);
        clr_pulse();
        quarters(1, 1, 10); tick(5);
        tick(66000);
        check("idle_per", 32'(period), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
